timestamp_gen_multi: RTL and testbench
======================================

# timestamp_gen_multi

Multi-channel timestamp generator for the flow tables. Each of `NUM_CHANNELS` channels keeps an independent `TIMESTAMP_WIDTH`-bit timestamp. A channel's timestamp advances once per programmable unit of clock cycles, so flow-aging logic can use several time resolutions from one block. The generator adds global enable/clear, runtime unit reprogramming that takes effect glitch-free at a unit boundary, and per-channel tick/wrap pulses.

## Interface
- `NUM_CHANNELS`, 2: number of independent timestamp channels (≥1).
- `TIMESTAMP_WIDTH`, 5: width of each channel's timestamp.
- `TIMESTAMP_UNIT_WIDTH`, 32: width of unit and cycle counters.
- `DEFAULT_UNIT`, 1 << (TIMESTAMP_UNIT_WIDTH-1): reset unit for every channel, in cycles; must be nonzero.
- `CHAN_IDX_WIDTH`, $clog2(NUM_CHANNELS) (min 1): width of `cfg_channel`.

Ports:
- `clk`  in  1  single clock; all logic is posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  when low, all counters and timestamps hold and no pulses are produced.
- `clear`  in  1  synchronous clear of all cycle counters and timestamps; units are kept.
- `cfg_valid`  in  1  one-cycle unit write strobe.
- `cfg_channel`  in  CHAN_IDX_WIDTH  target channel of the write.
- `cfg_unit`  in  TIMESTAMP_UNIT_WIDTH  new unit, in cycles.
- `cfg_error`  out  1  registered pulse when a write is rejected.
- `timestamp`  out  NUM_CHANNELS*TIMESTAMP_WIDTH  channel c occupies bits [c*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH].
- `tick`  out  NUM_CHANNELS  one-cycle pulse per channel, asserted in the cycle its new timestamp value is first visible.
- `wrap`  out  NUM_CHANNELS  one-cycle pulse, asserted together with `tick` when the timestamp goes from all-ones to 0.

## Operation
- Each channel holds the following registers: `unit`, `counter`, `timestamp`, `pending_unit`, `pending_valid`.
- Reset: `unit`=DEFAULT_UNIT; `counter`=0; `timestamp`=0; `pending_valid`=0; `tick`=0; `wrap`=0; `cfg_error`=0.
- Counting, when `enable`=1 and `clear`=0:
  - If `counter`==`unit`-1: `counter`←0, `timestamp`←`timestamp`+1 (modulo 2^TIMESTAMP_WIDTH), `tick`←1, and `wrap`←1 if the old timestamp was all-ones.
  - Otherwise: `counter`←`counter`+1.
- Unit change:
  - An accepted write stores `pending_unit`←`cfg_unit` and sets `pending_valid`←1 for the selected channel.
  - A second write before it is applied overwrites the pending value; the last write wins.
  - The pending unit is applied at the next boundary (`counter`==`unit`-1 while enabled). At that point `unit`←`pending_unit` and `pending_valid`←0.
  - The period that is currently running always completes with the old unit.
- Write rejection: a write is rejected if `cfg_unit`==0 or `cfg_channel`≥NUM_CHANNELS. On rejection, `cfg_error`←1 for one cycle and no state changes.
- `clear`=1 (regardless of `enable`):
  - Every channel's `counter`←0 and `timestamp`←0.
  - Any pending unit is applied immediately.
  - `tick` and `wrap` are 0.
- `enable`=0: counters and timestamps freeze. Writes are still accepted and remain pending. Pending units are applied only by a boundary or by `clear`.
- Simultaneous write and `clear`, same cycle and same channel: `clear` applies the old pending value, if any, and the new write becomes pending.
- Simultaneous write and boundary, same cycle and same channel: the boundary applies the previous pending value, if any, and the new write becomes pending for the following boundary.
- Unit 1: the timestamp increments every enabled cycle and `tick` stays high continuously.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- First tick after reset or clear with unit U and `enable` held high: `tick` is high in the cycle after the U-th enabled cycle. Equivalently, the timestamp changes at the U-th enabled clock edge.
- `cfg_error` is high in the cycle after the strobe.
- A write accepted in cycle t can take effect at the earliest for the period starting after the next boundary at or after t+1.
- `reset` overrides `clear`, `enable` and cfg; `reset` in mid-period discards both the period and any pending unit.

## Structure
- Sub-module `timestamp_channel`: one instance per channel, generated. It holds `unit`, `counter`, `timestamp` and pending state, and has inputs enable, clear, wr_en and wr_unit.
- The top level does write decode, `cfg_error` generation and output concatenation.
- The shared flows package or header holds `TIMESTAMP_WIDTH` and `TIMESTAMP_UNIT_WIDTH` defaults, and the channel-slice helper macro. These are shared with the flow table's aging logic.

## Test plan
All scenarios use TIMESTAMP_WIDTH=3, DEFAULT_UNIT=4, NUM_CHANNELS=2.
- Reset, then `enable`=1 for 40 cycles → both channels tick every 4 cycles. Timestamps run 1..7, 0. `wrap` pulses only on the 7→0 tick, at the 32nd cycle.
- Write unit 2 to channel 1 at `counter`=1 → the current period still ends at 4 cycles, then ticks come every 2 cycles. Channel 0 is unaffected.
- `cfg_unit`=0, and separately `cfg_channel`=2 → `cfg_error` pulses one cycle after each write. Units are unchanged.
- `enable` low for 10 cycles at `counter`=2 → timestamp and counter hold and there is no tick. The tick arrives 2 cycles after re-enable.
- Write unit 3 with `enable`=0, then pulse `clear` → timestamps are 0 and the next tick comes 3 cycles after `clear` with `enable`=1.
- Assert `reset` mid-period with a unit write pending → the state returns to reset values, and subsequent ticks use the 4-cycle unit.

Source files
------------

// File: rtl/timestamp_gen_multi_pkg.sv
// ============================================================================
// Module  : timestamp_gen_multi_pkg
// Brief   : Shared timestamp defaults and channel-slice helper for flow aging.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package timestamp_gen_multi_pkg;

  localparam int TS_WIDTH_DEFAULT      = 5;
  localparam int TS_UNIT_WIDTH_DEFAULT = 32;

  function automatic int chan_idx_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// Selects channel c's field out of a packed per-channel vector of width w.
`define TSG_CHAN_SLICE(c, w) ((c)*(w)) +: (w)

`default_nettype wire

// File: rtl/timestamp_gen_multi_if.sv
// ============================================================================
// Module  : timestamp_gen_multi_if
// Brief   : Unit-programming bus of the multi-channel timestamp generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface timestamp_gen_multi_if
  import timestamp_gen_multi_pkg::*;
#(
  parameter int CHAN_IDX_WIDTH = 1,
  parameter int UNIT_WIDTH     = TS_UNIT_WIDTH_DEFAULT
);

  logic                      cfg_valid;
  logic [CHAN_IDX_WIDTH-1:0] cfg_channel;
  logic [UNIT_WIDTH-1:0]     cfg_unit;
  logic                      cfg_error;

  modport master (
    output cfg_valid,
    output cfg_channel,
    output cfg_unit,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  cfg_channel,
    input  cfg_unit,
    output cfg_error
  );

endinterface

`default_nettype wire

// File: rtl/timestamp_channel.sv
// ============================================================================
// Module  : timestamp_channel
// Brief   : One timestamp channel with programmable unit and deferred reload.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timestamp_channel
  import timestamp_gen_multi_pkg::*;
#(
  parameter int                              TIMESTAMP_WIDTH      = TS_WIDTH_DEFAULT,
  parameter int                              TIMESTAMP_UNIT_WIDTH = TS_UNIT_WIDTH_DEFAULT,
  parameter logic [TIMESTAMP_UNIT_WIDTH-1:0] DEFAULT_UNIT         =
      TIMESTAMP_UNIT_WIDTH'(1) << (TIMESTAMP_UNIT_WIDTH-1)
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  input  wire logic                            enable,
  input  wire logic                            clear,
  input  wire logic                            wr_en,
  input  wire logic [TIMESTAMP_UNIT_WIDTH-1:0] wr_unit,
  output logic      [TIMESTAMP_WIDTH-1:0]      timestamp,
  output logic                                 tick,
  output logic                                 wrap
);

  logic [TIMESTAMP_UNIT_WIDTH-1:0] r_unit;
  logic [TIMESTAMP_UNIT_WIDTH-1:0] r_counter;
  logic [TIMESTAMP_UNIT_WIDTH-1:0] r_pending_unit;
  logic                            r_pending_valid;
  logic                            w_boundary;

  assign w_boundary = enable && !clear &&
                      (r_counter == (r_unit - TIMESTAMP_UNIT_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_unit          <= DEFAULT_UNIT;
      r_counter       <= '0;
      r_pending_unit  <= '0;
      r_pending_valid <= 1'b0;
      timestamp       <= '0;
      tick            <= 1'b0;
      wrap            <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        r_counter <= '0;
        timestamp <= '0;
        if (r_pending_valid) begin
          r_unit          <= r_pending_unit;
          r_pending_valid <= 1'b0;
        end
      end else if (w_boundary) begin
        r_counter <= '0;
        timestamp <= timestamp + TIMESTAMP_WIDTH'(1);
        tick      <= 1'b1;
        wrap      <= &timestamp;
        if (r_pending_valid) begin
          r_unit          <= r_pending_unit;
          r_pending_valid <= 1'b0;
        end
      end else if (enable) begin
        r_counter <= r_counter + TIMESTAMP_UNIT_WIDTH'(1);
      end
      // A same-cycle write lands after any apply above, so it stays pending.
      if (wr_en) begin
        r_pending_unit  <= wr_unit;
        r_pending_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timestamp_gen_multi.sv
// ============================================================================
// Module  : timestamp_gen_multi
// Brief   : Multi-channel timestamp generator: write decode, error, outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timestamp_gen_multi
  import timestamp_gen_multi_pkg::*;
#(
  parameter int                              NUM_CHANNELS         = 2,
  parameter int                              TIMESTAMP_WIDTH      = TS_WIDTH_DEFAULT,
  parameter int                              TIMESTAMP_UNIT_WIDTH = TS_UNIT_WIDTH_DEFAULT,
  parameter logic [TIMESTAMP_UNIT_WIDTH-1:0] DEFAULT_UNIT         =
      TIMESTAMP_UNIT_WIDTH'(1) << (TIMESTAMP_UNIT_WIDTH-1),
  parameter int                              CHAN_IDX_WIDTH       = chan_idx_width(NUM_CHANNELS)
) (
  input  wire logic                                    clk,
  input  wire logic                                    reset,
  input  wire logic                                    enable,
  input  wire logic                                    clear,
  timestamp_gen_multi_if.slave                         cfg,
  output logic [NUM_CHANNELS*TIMESTAMP_WIDTH-1:0]      timestamp,
  output logic [NUM_CHANNELS-1:0]                      tick,
  output logic [NUM_CHANNELS-1:0]                      wrap
);

  localparam logic [CHAN_IDX_WIDTH:0] C_NUM_CHAN = (CHAN_IDX_WIDTH+1)'(NUM_CHANNELS);

  logic w_unit_ok;
  logic w_chan_ok;
  logic w_accept;

  assign w_unit_ok = (cfg.cfg_unit != '0);
  assign w_chan_ok = ({1'b0, cfg.cfg_channel} < C_NUM_CHAN);
  assign w_accept  = cfg.cfg_valid && w_unit_ok && w_chan_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg.cfg_error <= 1'b0;
    end else begin
      cfg.cfg_error <= cfg.cfg_valid && !w_accept;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic w_wr_en;
    assign w_wr_en = w_accept && (cfg.cfg_channel == CHAN_IDX_WIDTH'(c));

    timestamp_channel #(
      .TIMESTAMP_WIDTH      (TIMESTAMP_WIDTH),
      .TIMESTAMP_UNIT_WIDTH (TIMESTAMP_UNIT_WIDTH),
      .DEFAULT_UNIT         (DEFAULT_UNIT)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .clear     (clear),
      .wr_en     (w_wr_en),
      .wr_unit   (cfg.cfg_unit),
      .timestamp (timestamp[`TSG_CHAN_SLICE(c, TIMESTAMP_WIDTH)]),
      .tick      (tick[c]),
      .wrap      (wrap[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_timestamp_gen_multi.sv
// ============================================================================
// Module  : tb_timestamp_gen_multi
// Brief   : Scoreboard bench: countdown reference model vs. timestamp_gen_multi.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timestamp_gen_multi;

  localparam int NC  = 2;
  localparam int TW  = 3;
  localparam int UW  = 32;
  localparam int CIW = 2;
  localparam int DU  = 4;

  typedef struct packed {
    logic [NC*TW-1:0] ts;
    logic [NC-1:0]    tick;
    logic [NC-1:0]    wrap;
    logic             err;
  } exp_t;

  logic clk;
  logic reset;
  logic enable;
  logic clear;
  logic [NC*TW-1:0] timestamp;
  logic [NC-1:0]    tick;
  logic [NC-1:0]    wrap;

  timestamp_gen_multi_if #(.CHAN_IDX_WIDTH(CIW), .UNIT_WIDTH(UW)) cfg_if ();

  timestamp_gen_multi #(
    .NUM_CHANNELS         (NC),
    .TIMESTAMP_WIDTH      (TW),
    .TIMESTAMP_UNIT_WIDTH (UW),
    .DEFAULT_UNIT         (UW'(DU)),
    .CHAN_IDX_WIDTH       (CIW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .cfg       (cfg_if),
    .timestamp (timestamp),
    .tick      (tick),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: each channel counts down the cycles left in its running period.
  int m_unit[NC];
  int m_left[NC];
  int m_ts[NC];
  int m_pu[NC];
  bit m_pv[NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit cl,
                     input bit v, input int ch, input int u);
    exp_t e;
    bit   rej;
    @(negedge clk);
    reset              = r;
    enable             = en;
    clear              = cl;
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_channel = CIW'(ch);
    cfg_if.cfg_unit    = UW'(u);
    e   = '0;
    rej = v && (u == 0 || ch >= NC);
    e.err = !r && rej;
    for (int c = 0; c < NC; c++) begin
      if (r) begin
        m_unit[c] = DU; m_left[c] = DU; m_ts[c] = 0; m_pv[c] = 0;
      end else begin
        if (cl) begin
          if (m_pv[c]) begin m_unit[c] = m_pu[c]; m_pv[c] = 0; end
          m_left[c] = m_unit[c];
          m_ts[c]   = 0;
        end else if (en) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            m_ts[c]   = (m_ts[c] + 1) % (1 << TW);
            e.tick[c] = 1'b1;
            e.wrap[c] = (m_ts[c] == 0);
            if (m_pv[c]) begin m_unit[c] = m_pu[c]; m_pv[c] = 0; end
            m_left[c] = m_unit[c];
          end
        end
        if (v && !rej && ch == c) begin
          m_pu[c] = u;
          m_pv[c] = 1;
        end
      end
      e.ts[c*TW +: TW] = TW'(m_ts[c]);
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("timestamp", 32'(timestamp), 32'(e.ts));
        chk("tick",      32'(tick),      32'(e.tick));
        chk("wrap",      32'(wrap),      32'(e.wrap));
        chk("cfg_error", 32'(cfg_if.cfg_error), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_channel = '0; cfg_if.cfg_unit = '0;

    // Free run through a full wrap.
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (40) cyc(0, 1, 0, 0, 0, 0);

    // Unit change on channel 1 mid-period.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 2);
    repeat (20) cyc(0, 1, 0, 0, 0, 0);

    // Rejected writes.
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 2, 5);
    cyc(0, 1, 0, 1, 3, 1);
    repeat (12) cyc(0, 1, 0, 0, 0, 0);

    // Enable gap at counter 2.
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 0, 0, 0);

    // Pending write applied by clear.
    cyc(0, 0, 0, 1, 0, 3);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0, 0, 0);

    // Write coincident with clear and with a boundary.
    cyc(0, 1, 1, 1, 1, 1);
    repeat (4) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 0, 0);

    // Reset discards a pending unit.
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 7);
    cyc(1, 1, 0, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, en, cl, v;
      int ch, u;
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      cl = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 5) == 0);
      ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      u  = int'($urandom_range(0, 6));
      cyc(r, en, cl, v, ch, u);
    end

    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
